// File: rtl/mul_issue_ctrl_pkg.sv
// ============================================================================
// Module      : mul_issue_ctrl_pkg
// Description : Op encodings and the MULHU correction helper for mul_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_issue_ctrl_pkg;

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_MULH  = 2'b01;
  localparam logic [1:0] MUL_OP_MULHU = 2'b10;

  // Adding this to the signed high word yields the unsigned high word.
  function automatic logic [31:0] mulhu_corr(input logic [31:0] a, input logic [31:0] b);
    return (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_issue_ctrl_mul.sv
// ============================================================================
// Module      : mul_top
// Description : 32x32 signed multiplier; product registered once, valid the cycle after inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_top (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [63:0] w_prod;
  logic [63:0] r_result;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign w_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      r_result <= 64'd0;
    end else begin
      r_result <= w_prod;
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
// ============================================================================
// Module      : mul_issue_ctrl
// Description : Issue/return control for the multiplier with 1-entry result hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             r_s2_valid;
  logic [1:0]       r_s2_op;
  logic [TAG_W-1:0] r_s2_tag;
  logic [31:0]      r_s2_corr;
  logic             r_hold_valid;
  logic [31:0]      r_hold_result;
  logic [TAG_W-1:0] r_hold_tag;

  logic             w_in_fire;
  logic [63:0]      w_prod;
  logic [31:0]      w_live;

  mul_top u_mul (
    .mul_clk (mul_clk),
    .resetn  (resetn),
    .a       (in_src1),
    .b       (in_src2),
    .result  (w_prod)
  );

  assign in_ready  = out_ready | (~r_hold_valid & ~r_s2_valid);
  assign w_in_fire = in_valid & in_ready & ~flush;
  assign busy      = r_s2_valid | r_hold_valid;

  // Reserved encoding 2'b11 falls into the default arm and behaves as MUL.
  always_comb begin
    w_live = w_prod[31:0];
    case (r_s2_op)
      MUL_OP_MULH:  w_live = w_prod[63:32];
      MUL_OP_MULHU: w_live = w_prod[63:32] + r_s2_corr;
      default:      w_live = w_prod[31:0];
    endcase
  end

  always_comb begin
    out_valid  = 1'b0;
    out_result = 32'd0;
    out_tag    = '0;
    if (r_hold_valid) begin
      out_valid  = 1'b1;
      out_result = r_hold_result;
      out_tag    = r_hold_tag;
    end else if (r_s2_valid) begin
      out_valid  = 1'b1;
      out_result = w_live;
      out_tag    = r_s2_tag;
    end
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid    <= 1'b0;
      r_s2_op       <= 2'b00;
      r_s2_tag      <= '0;
      r_s2_corr     <= 32'd0;
      r_hold_valid  <= 1'b0;
      r_hold_result <= 32'd0;
      r_hold_tag    <= '0;
    end else if (flush) begin
      r_s2_valid   <= 1'b0;
      r_hold_valid <= 1'b0;
    end else begin
      r_s2_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s2_op   <= in_op;
        r_s2_tag  <= in_tag;
        r_s2_corr <= mulhu_corr(in_src1, in_src2);
      end
      // The product lives only one cycle, so a stalled result must be captured now.
      if (r_s2_valid && !out_ready) begin
        r_hold_valid  <= 1'b1;
        r_hold_result <= w_live;
        r_hold_tag    <= r_s2_tag;
      end else if (r_hold_valid && out_ready) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Issue/return controller that sequences the 2-stage 32-bit signed multiplier (mul_top) for the execute stage. Accepts multiply ops over a valid/ready handshake and tracks the one in-flight op. Selects MUL/MULH/MULHU results, deriving the unsigned high word by correcting the signed product. Holds results in a 1-entry buffer when the consumer stalls, and supports pipeline flush.

Parameters:
TAG_W, 5, width of destination tag carried alongside each op (e.g. rd index)

Ports:
mul_clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  op request
in_ready  out  1  controller can accept op this cycle
in_op  in  2  00 MUL (low word), 01 MULH (signed high), 10 MULHU (unsigned high), 11 reserved (treated as 00)
in_src1  in  32  operand a
in_src2  in  32  operand b
in_tag  in  TAG_W  tag returned with result
flush  in  1  synchronous kill of all in-flight/held ops
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  32  selected result word
out_tag  out  TAG_W  tag of out_result
busy  out  1  s2_valid | hold_valid

Behaviour:
- Clock mul_clk; reset resetn is asynchronous and active-low. mul_top gets the same mul_clk/resetn. in_src1/in_src2 feed mul_top directly every cycle. Its stage-2 register updates unconditionally, so a product is visible only in the cycle after issue.
- in_fire = in_valid & in_ready & !flush. out_fire = out_valid & out_ready.
- State regs: s2_valid, s2_op, s2_tag, s2_corr[31:0]; hold_valid, hold_result[31:0], hold_tag. All reset to 0.
- s2_corr registered on in_fire: (src1[31] ? src2 : 0) + (src2[31] ? src1 : 0), mod 2^32.
- Live result, from mul_top result r[63:0] and s2_op:
  - MUL: r[31:0].
  - MULH: r[63:32].
  - MULHU: r[63:32] + s2_corr, mod 2^32.
- Invariant: never hold_valid & s2_valid. Assert this in the bench.
- Output mux:
  - hold_valid: out_valid=1, data = hold_result/hold_tag.
  - else s2_valid: out_valid=1, data = live result/s2_tag.
  - else: out_valid=0, out_result=0, out_tag=0.
- in_ready = out_ready | (!hold_valid & !s2_valid). This gives throughput of 1 op/cycle while the consumer is ready. in_ready may depend combinationally on out_ready; it does not depend on in_valid.
- Next state, no flush:
  - s2_valid <= in_fire.
  - If s2_valid & !out_ready: hold <= live result/tag, hold_valid <= 1.
  - Else if hold_valid & out_ready: hold_valid <= 0.
- Latency: issue in cycle N, result on out in cycle N+1. If stalled, it stays on out from the hold buffer until out_fire. Results return in issue order.
- Flush:
  - Clears s2_valid and hold_valid at the next edge.
  - Suppresses in_fire that cycle.
  - out_valid is still driven that cycle; a result consumed in the flush cycle counts as delivered.
- Reset mid-operation: all state cleared immediately and asynchronously; the pending result is lost. out_valid=0 while resetn=0, and in_ready=1 from the first cycle after reset release.
- Reserved op 11 behaves exactly as MUL.

Decomposition:
- Shared header (mul.h): op encodings MUL_OP_MUL=2'b00, MUL_OP_MULH=2'b01, MUL_OP_MULHU=2'b10.
- One sub-module: mul_top instance (u_mul). Correction adder, hold buffer and handshake logic stay in mul_issue_ctrl.

Test Plan:
- MUL, -3 (0xFFFFFFFD) * 7, tag 5, out_ready=1 -> next cycle out_valid=1, out_result=0xFFFFFFEB, out_tag=5; then out_valid=0.
- MULH vs MULHU, each operand pair issued under both ops:
  - 0xFFFFFFFF*0xFFFFFFFF -> MULH 0x00000000, MULHU 0xFFFFFFFE.
  - 0x80000000*0x80000000 -> MULH 0x40000000, MULHU 0x40000000.
  - 0x80000000*0x00000002 -> MULH 0xFFFFFFFF, MULHU 0x00000001.
- Four back-to-back MULs, tags 1..4, out_ready=1 -> in_ready stays 1; results in cycles N+1..N+4, in order, one per cycle.
- Issue op, drop out_ready for 3 cycles:
  - out_result/out_tag held stable from hold buffer.
  - in_ready=0 while in_valid=1.
  - On out_ready=1 -> result delivered, and the next op is accepted in the same cycle.
- Hold full, assert flush with in_valid=1 -> next cycle out_valid=0, busy=0; no result for either op ever appears.
- Assert resetn=0 the cycle after issue -> out_valid drops immediately; after release, in_ready=1 and a new MUL 6*7 returns 0x0000002A.
